// File: rtl/fizzbuzz_encoder_if.sv
// fizzbuzz_encoder_if: flag inputs, token output stream and status for fizzbuzz_encoder.
interface fizzbuzz_encoder_if #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 7,
  parameter int TALLY_W = 8
);
  logic                       in_valid;
  logic                       in_fizz;
  logic                       in_buzz;
  logic                       in_fizzbuzz;
  logic                       out_valid;
  logic                       out_ready;
  logic [1:0]                 out_code;
  logic [IDX_W-1:0]           out_idx;
  logic [$clog2(DEPTH):0]     level;
  logic                       overflow;
  logic [TALLY_W-1:0]         tally_plain;
  logic [TALLY_W-1:0]         tally_fizz;
  logic [TALLY_W-1:0]         tally_buzz;
  logic [TALLY_W-1:0]         tally_fb;
  modport master (
    output in_valid, in_fizz, in_buzz, in_fizzbuzz, out_ready,
    input  out_valid, out_code, out_idx, level, overflow,
           tally_plain, tally_fizz, tally_buzz, tally_fb
  );
  modport slave (
    input  in_valid, in_fizz, in_buzz, in_fizzbuzz, out_ready,
    output out_valid, out_code, out_idx, level, overflow,
           tally_plain, tally_fizz, tally_buzz, tally_fb
  );
endinterface

// File: rtl/fizzbuzz_encoder.sv
// fizzbuzz_encoder: classifies flag cycles into indexed tokens buffered in a FIFO.
// Optional saturating class tallies are built when FIZZBUZZ_ENCODER_TALLY_EN is defined.
module fizzbuzz_encoder #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 7,
  parameter int TALLY_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  fizzbuzz_encoder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [1:0]         w_code;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_drop;
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [LW-1:0]      r_level;
  logic [IDX_W-1:0]   r_seq;
  logic               r_overflow;
  logic [IDX_W+1:0]   r_mem [DEPTH];
  always_comb begin
    w_code = (bus.in_fizzbuzz || (bus.in_fizz && bus.in_buzz)) ? 2'd3 :
             bus.in_fizz ? 2'd1 : bus.in_buzz ? 2'd2 : 2'd0;
    w_full = r_level == LW'(DEPTH);
    w_pop  = (r_level != '0) && bus.out_ready;
    w_push = bus.in_valid && (!w_full || w_pop);
    w_drop = bus.in_valid && w_full && !w_pop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.in_valid) r_seq <= r_seq + IDX_W'(1);
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop) r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end
  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wp] <= {w_code, r_seq};
  end
  assign bus.out_valid = r_level != '0;
  assign bus.out_code  = bus.out_valid ? r_mem[r_rp][IDX_W+1:IDX_W] : 2'd0;
  assign bus.out_idx   = bus.out_valid ? r_mem[r_rp][IDX_W-1:0] : '0;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
`ifdef FIZZBUZZ_ENCODER_TALLY_EN
  logic [TALLY_W-1:0] r_tally [4];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_tally[i] <= '0;
    end else if (bus.in_valid && r_tally[w_code] != '1) begin
      r_tally[w_code] <= r_tally[w_code] + TALLY_W'(1);
    end
  end
  assign bus.tally_plain = r_tally[0];
  assign bus.tally_fizz  = r_tally[1];
  assign bus.tally_buzz  = r_tally[2];
  assign bus.tally_fb    = r_tally[3];
`else
  assign bus.tally_plain = {TALLY_W{1'b0}};
  assign bus.tally_fizz  = {TALLY_W{1'b0}};
  assign bus.tally_buzz  = {TALLY_W{1'b0}};
  assign bus.tally_fb    = {TALLY_W{1'b0}};
`endif
endmodule

// File: doc/fizzbuzz_encoder.md
# fizzbuzz_encoder

Downstream consumer of the per-cycle fizz/buzz/fizzbuzz flag stage. It classifies each valid input cycle into a 2-bit code, tags it with a wrapping sequence index, and buffers the resulting tokens in a small FIFO. The FIFO drains through a valid/ready output stream. Dropped tokens are flagged with a sticky overflow bit, and optional per-class tallies are kept.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- IDX_W, 7, sequence index width
- TALLY_W, 8, width of each tally counter (used only with tallies compiled in)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  flags below are meaningful this cycle
- in_fizz  in  1  fizz flag from the upstream stage
- in_buzz  in  1  buzz flag from the upstream stage
- in_fizzbuzz  in  1  fizzbuzz flag from the upstream stage
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head token
- out_code  out  2  head code: 0 plain, 1 fizz, 2 buzz, 3 fizzbuzz
- out_idx  out  IDX_W  head sequence index
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a token was dropped
- tally_plain, tally_fizz, tally_buzz, tally_fb  out  TALLY_W each  class tallies

## Operation
Classification is combinational on the inputs, with this priority:
- in_fizzbuzz, or in_fizz together with in_buzz → 3
- else in_fizz → 1
- else in_buzz → 2
- else → 0

Sequence index:
- Register `seq` increments by 1 on every in_valid cycle, whether the token is accepted or dropped.
- It wraps from 2^IDX_W−1 to 0.
- The token carries the pre-increment value, so drops appear as gaps in out_idx.

FIFO:
- Push = in_valid and (level < DEPTH, or pop this cycle).
- Pop = out_valid and out_ready.
- Simultaneous push and pop when full: both happen and level stays at DEPTH.
- Simultaneous push and pop when empty: pop is not possible; the push happens and level becomes 1.

Drop:
- Condition: in_valid while full with no pop.
- The token is discarded and overflow is set to 1.
- overflow clears only on reset.

Output values:
- When out_valid = 0, out_code and out_idx are driven 0.
- When out_valid = 1, out_code/out_idx hold the head token and must stay stable until it is popped.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.

Tallies:
- Each in_valid cycle increments the tally for its class, including dropped tokens.
- Tallies saturate at 2^TALLY_W−1 and do not wrap.

Reset:
- Applies on any cycle, including mid-stream.
- Resets: seq=0, level=0, overflow=0, all tallies=0, out_valid=0, out_code=0, out_idx=0.
- FIFO contents are discarded.
- Inputs are ignored during reset cycles.

## Timing
- Input to output latency is 1 cycle: a token pushed at edge N is visible (out_valid=1) after edge N when the FIFO was empty.
- There is no combinational path from in_* to out_*.
- out_ready affects only the next-state pop decision and the push-when-full decision, which is combinational to the push enable.
- Throughput is one token per cycle with out_ready held high.
- overflow, level and tallies update on the same edge as the event that causes them.

## Configuration
- Macro: FIZZBUZZ_ENCODER_TALLY_EN.
- Defined: the four saturating tally counters are built as described.
- Undefined:
  - No tally registers are instantiated.
  - The tally_* ports remain present and are tied to 0.
  - TALLY_W is unused.
  - All other behaviour is identical.

## Test plan
- Reset, then 15 in_valid cycles driven like an upstream counter 0..14 (flags for 0, 3, 5, 6, 9, 10, 12), out_ready=1.
  - Expect codes 3,0,0,1,0,2,1,0,0,1,2,0,1,0,0 with idx 0..14.
  - Each token appears 1 cycle after its input.
  - overflow stays 0.
- DEPTH=4, out_ready=0, 6 valid inputs.
  - Expect level reaches 4; inputs 5 and 6 are dropped; overflow=1.
  - Raising out_ready then drains idx 0,1,2,3, followed by no idx 4 or 5.
- Full FIFO with out_ready=1 and in_valid=1 on the same cycle.
  - Expect level stays 4 and no drop.
  - The popped head is idx k; the new tail is idx k+4.
- 130 valid inputs with IDX_W=7.
  - Expect out_idx wraps 127→0.
- With FIZZBUZZ_ENCODER_TALLY_EN and TALLY_W=4, 20 fizz-only inputs.
  - Expect tally_fizz saturates at 15 and the other tallies stay 0.
  - Without the macro, all tallies read 0.
- Assert reset with level=3 and overflow=1.
  - Expect all outputs 0 on the next cycle.
  - The first token after reset carries idx 0.
